lsu_mem_ctrl: RTL and testbench

//   MEM-stage load/store controller sitting directly upstream of data_memory.

---
 rtl/lsu_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_ctrl
//  Description : MEM-stage load/store controller in front of a word-wide
//                data_memory. Extracts and extends load lanes, performs
//                sub-word stores as a two-cycle read-modify-write with a
//                pipeline stall, and suppresses misaligned requests while
//                flagging them with a registered one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        misalign,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      MRG_WR = 1'b1
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] lat_idx;
   logic [31:0]       merge_word;

   logic              is_b, is_h, is_w, is_bu, is_hu;
   logic              legal;
   logic              bad_align;
   logic              accept;
   logic              sub_store;
   logic              misalign_nxt;
   logic [ADDR_W-1:0] word_idx;
   logic [7:0]        byte_val;
   logic [15:0]       half_val;
   logic [31:0]       ext_data;
   logic [31:0]       merged;
   logic              unused_addr;

   assign is_b  = (req_funct3 == F3_B);
   assign is_h  = (req_funct3 == F3_H);
   assign is_w  = (req_funct3 == F3_W);
   assign is_bu = (req_funct3 == F3_BU);
   assign is_hu = (req_funct3 == F3_HU);

   // Unsigned load widths have no store counterpart, so they are illegal with we=1.
   assign legal     = is_b | is_h | is_w | (~req_we & (is_bu | is_hu));
   assign bad_align = ((is_h | is_hu) & req_addr[0]) |
                      (is_w & (req_addr[1:0] != 2'b00));

   // A request is acted upon only in IDLE, out of reset, legal and aligned.
   assign accept    = rst_n & req_valid & legal & ~bad_align & (state == IDLE);
   assign sub_store = accept & req_we & (is_b | is_h);

   // Illegal funct3 is a silent no-op; only legal-but-misaligned raises the flag.
   assign misalign_nxt = req_valid & legal & bad_align & (state == IDLE);

   // Upper address bits beyond the word index are deliberately ignored.
   assign word_idx    = req_addr[ADDR_W+1:2];
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   // Select the addressed byte and halfword lanes of the read word.
   always_comb begin
      byte_val = mem_rd[7:0];
      case (req_addr[1:0])
         2'd0:    byte_val = mem_rd[7:0];
         2'd1:    byte_val = mem_rd[15:8];
         2'd2:    byte_val = mem_rd[23:16];
         default: byte_val = mem_rd[31:24];
      endcase
      half_val = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
   end

   // Sign- or zero-extend the selected lane according to the load type.
   always_comb begin
      ext_data = mem_rd;
      case (req_funct3)
         F3_B:    ext_data = {{24{byte_val[7]}}, byte_val};
         F3_H:    ext_data = {{16{half_val[15]}}, half_val};
         F3_BU:   ext_data = {24'h0, byte_val};
         F3_HU:   ext_data = {16'h0, half_val};
         default: ext_data = mem_rd;
      endcase
   end

   // Build the store-merged word: current memory word with one lane replaced.
   always_comb begin
      merged = mem_rd;
      if (is_b) begin
         merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      end else begin
         merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      end
   end

   // Next-state and memory-side outputs; reset forces the side-effecting outputs off.
   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      stall     = 1'b0;
      load_data = 32'h0;
      mem_addr  = {{(32-ADDR_W){1'b0}}, word_idx};
      mem_wd    = req_wdata;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!req_we) begin
                  load_data = ext_data;
               end else if (is_w) begin
                  mem_we = 1'b1;
               end else begin
                  stall     = 1'b1;
                  state_nxt = MRG_WR;
               end
            end
         end
         MRG_WR: begin
            mem_we    = 1'b1;
            mem_addr  = {{(32-ADDR_W){1'b0}}, lat_idx};
            mem_wd    = merge_word;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!rst_n) begin
         mem_we    = 1'b0;
         stall     = 1'b0;
         load_data = 32'h0;
      end
   end

   // State register, misalign pulse and read-modify-write capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         misalign   <= 1'b0;
         lat_idx    <= '0;
         merge_word <= 32'h0;
      end else begin
         state    <= state_nxt;
         misalign <= misalign_nxt;
         if (sub_store) begin
            lat_idx    <= word_idx;
            merge_word <= merged;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_ctrl
//  Description : Self-checking bench for lsu_mem_ctrl with a word-wide
//                data_memory model and a behavioural reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        misalign;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   int pass_cnt = 0;
   int total    = 0;
   int wr_cnt   = 0;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic        clr;
   logic        pl_en;
   logic [9:0]  pl_idx;
   logic [31:0] pl_data;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.ADDR_W(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .load_data  (load_data),
      .misalign   (misalign),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   // data_memory model: combinational read, synchronous write
   assign mem_rd = mem[mem_addr[9:0]];

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      end else if (pl_en) begin
         mem[pl_idx] <= pl_data;
      end
      if (mem_we) begin
         mem[mem_addr[9:0]] <= mem_wd;
         wr_cnt <= wr_cnt + 1;
      end
   end

   // ---------------- reference model (arithmetic on the rules) -------------
   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
      longint unsigned wl, b, h;
      wl = 64'(w);
      b  = (wl / (64'd1 << (8 * off))) % 256;
      h  = (wl / (64'd1 << (16 * off[1]))) % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
         3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h);
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off, input logic [31:0] d);
      logic [31:0] mask, ins;
      if (f3 == 3'd0) begin
         mask = 32'hFF << (8 * off);
         ins  = (d & 32'hFF) << (8 * off);
      end else begin
         mask = 32'hFFFF << (16 * off[1]);
         ins  = (d & 32'hFFFF) << (16 * off[1]);
      end
      return (w & ~mask) | ins;
   endfunction

   // ---------------- stimulus helpers (no checking) -------------------------
   task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
      req_valid  = v;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      @(negedge clk);
      set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      pl_en   = 1'b1;
      pl_idx  = 10'(idx);
      pl_data = d;
      @(posedge clk);
      #1;
      pl_en = 1'b0;
      ref_mem[idx] = d;
   endtask

   // ---------------- tests --------------------------------------------------
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_req(1'b1, 1'b1, 3'b010, 32'h10, 32'h12345678);
      #1;
      total++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_we); else pass_cnt++;
      total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (mem[4] !== 32'h0) $display("FAIL reset_nowrite: got %h want 0", mem[4]); else pass_cnt++;
      @(negedge clk);
      set_req(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
      #1;
      total++; if (load_data !== 32'h0) $display("FAIL reset_ld: got %h want 0", load_data); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (misalign !== 1'b0) $display("FAIL reset_mis: got %b want 0", misalign); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      #1;
      total++; if (stall !== 1'b0 || mem_we !== 1'b0) $display("FAIL idle_out: got stall=%b we=%b want 0/0", stall, mem_we); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_sw();
      @(negedge clk);
      set_req(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      #1;
      total++; if (mem_we !== 1'b1) $display("FAIL sw_we: got %b want 1", mem_we); else pass_cnt++;
      total++; if (mem_addr !== 32'd4) $display("FAIL sw_addr: got %h want 4", mem_addr); else pass_cnt++;
      total++; if (mem_wd !== 32'hDEADBEEF) $display("FAIL sw_wd: got %h want deadbeef", mem_wd); else pass_cnt++;
      total++; if (stall !== 1'b0) $display("FAIL sw_stall: got %b want 0", stall); else pass_cnt++;
      @(posedge clk); #1;
      ref_mem[4] = 32'hDEADBEEF;
      total++; if (mem[4] !== ref_mem[4]) $display("FAIL sw_mem: got %h want %h", mem[4], ref_mem[4]); else pass_cnt++;
   endtask

   task automatic test_sb();
      int w0;
      preload(4, 32'h11223344);
      w0 = wr_cnt;
      @(negedge clk);
      set_req(1'b1, 1'b1, 3'b000, 32'h11, 32'h000000AA);
      #1;
      total++; if (stall !== 1'b1 || mem_we !== 1'b0) $display("FAIL sb_c1: got stall=%b we=%b want 1/0", stall, mem_we); else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      set_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
      #1;
      total++; if (mem_we !== 1'b1 || stall !== 1'b0) $display("FAIL sb_c2: got we=%b stall=%b want 1/0", mem_we, stall); else pass_cnt++;
      total++; if (mem_wd !== 32'h1122AA44) $display("FAIL sb_wd: got %h want 1122aa44", mem_wd); else pass_cnt++;
      total++; if (mem_addr !== 32'd4) $display("FAIL sb_addr: got %h want 4", mem_addr); else pass_cnt++;
      total++; if (load_data !== 32'h0) $display("FAIL sb_ld: got %h want 0", load_data); else pass_cnt++;
      @(posedge clk); #1;
      ref_mem[4] = 32'h1122AA44;
      @(negedge clk);
      set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      #1;
      total++; if (mem_we !== 1'b0) $display("FAIL sb_c3: got we=%b want 0", mem_we); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (wr_cnt - w0 !== 1) $display("FAIL sb_wrcnt: got %0d want 1", wr_cnt - w0); else pass_cnt++;
      total++; if (mem[4] !== ref_mem[4]) $display("FAIL sb_mem: got %h want %h", mem[4], ref_mem[4]); else pass_cnt++;
   endtask

   task automatic test_loads();
      logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
      logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] exps [4] = '{32'hFFFFFF8A, 32'h0000008A, 32'hFFFF8A22, 32'h8A223344};
      preload(4, 32'h8A223344);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_req(1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
         #1;
         total++; if (load_data !== exps[i]) $display("FAIL load%0d: got %h want %h", i, load_data, exps[i]); else pass_cnt++;
         total++; if (mem_we !== 1'b0 || stall !== 1'b0) $display("FAIL load%0d_ctl: got we=%b stall=%b want 0/0", i, mem_we, stall); else pass_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_misalign();
      preload(4, 32'h55667788);
      @(negedge clk);
      set_req(1'b1, 1'b1, 3'b001, 32'h11, 32'h0000BEEF);
      #1;
      total++; if (mem_we !== 1'b0 || stall !== 1'b0) $display("FAIL mis_sh_ctl: got we=%b stall=%b want 0/0", mem_we, stall); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (misalign !== 1'b1) $display("FAIL mis_sh_pulse: got %b want 1", misalign); else pass_cnt++;
      @(negedge clk);
      set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      @(posedge clk); #1;
      total++; if (misalign !== 1'b0) $display("FAIL mis_sh_drop: got %b want 0", misalign); else pass_cnt++;
      total++; if (mem[4] !== ref_mem[4]) $display("FAIL mis_sh_mem: got %h want %h", mem[4], ref_mem[4]); else pass_cnt++;
      @(negedge clk);
      set_req(1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
      #1;
      total++; if (load_data !== 32'h0) $display("FAIL mis_lw_ld: got %h want 0", load_data); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (misalign !== 1'b1) $display("FAIL mis_lw_pulse: got %b want 1", misalign); else pass_cnt++;
      @(negedge clk);
      set_req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
      #1;
      total++; if (load_data !== 32'h0) $display("FAIL illegal_ld: got %h want 0", load_data); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (misalign !== 1'b0) $display("FAIL illegal_mis: got %b want 0", misalign); else pass_cnt++;
   endtask

   task automatic test_reset_mrg();
      int w0;
      preload(4, 32'h11223344);
      w0 = wr_cnt;
      @(negedge clk);
      set_req(1'b1, 1'b1, 3'b000, 32'h11, 32'h000000AA);
      #1;
      total++; if (stall !== 1'b1) $display("FAIL rmrg_stall: got %b want 1", stall); else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (mem_we !== 1'b0) $display("FAIL rmrg_we: got %b want 0", mem_we); else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1;
      set_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      #1;
      total++; if (load_data !== 32'h11223344 || mem_we !== 1'b0) $display("FAIL rmrg_idle: got ld=%h we=%b want 11223344/0", load_data, mem_we); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (mem[4] !== 32'h11223344 || wr_cnt != w0) $display("FAIL rmrg_mem: got %h writes=%0d want 11223344 writes=0", mem[4], wr_cnt - w0); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int w0;
      preload(4, 32'h0);
      preload(5, 32'h0);
      w0 = wr_cnt;
      @(negedge clk);
      set_req(1'b1, 1'b1, 3'b001, 32'h12, 32'h0000BEEF);
      #1;
      total++; if (stall !== 1'b1) $display("FAIL b2b_c1: got stall=%b want 1", stall); else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      #1;
      total++; if (mem_we !== 1'b1 || mem_addr !== 32'd4 || mem_wd !== 32'hBEEF0000) $display("FAIL b2b_c2: got we=%b a=%h d=%h want 1/4/beef0000", mem_we, mem_addr, mem_wd); else pass_cnt++;
      @(posedge clk); #1;
      @(negedge clk);
      set_req(1'b1, 1'b1, 3'b010, 32'h14, 32'hCAFEF00D);
      #1;
      total++; if (mem_we !== 1'b1 || mem_addr !== 32'd5 || stall !== 1'b0) $display("FAIL b2b_c3: got we=%b a=%h stall=%b want 1/5/0", mem_we, mem_addr, stall); else pass_cnt++;
      @(posedge clk); #1;
      ref_mem[4] = 32'hBEEF0000;
      ref_mem[5] = 32'hCAFEF00D;
      total++; if (mem[4] !== ref_mem[4] || mem[5] !== ref_mem[5]) $display("FAIL b2b_mem: got %h/%h want %h/%h", mem[4], mem[5], ref_mem[4], ref_mem[5]); else pass_cnt++;
      total++; if (wr_cnt - w0 !== 2) $display("FAIL b2b_wrcnt: got %0d want 2", wr_cnt - w0); else pass_cnt++;
   endtask

   task automatic test_random();
      logic        v, we, legal, mis;
      logic [2:0]  f3;
      logic [31:0] a, d, exp_ld, exp_wd;
      int          idx;
      for (int n = 0; n < 300; n++) begin
         v  = ($urandom_range(0, 9) != 0);
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         d  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1) a[11:2] = 10'($urandom_range(0, 7));
         idx   = int'(a[11:2]);
         legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
         mis   = legal && (((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00));
         exp_ld = (v && legal && !mis && !we) ? ref_load(ref_mem[idx], f3, a[1:0]) : 32'h0;
         @(negedge clk);
         set_req(v, we, f3, a, d);
         #1;
         total++; if (load_data !== exp_ld) $display("FAIL rnd%0d_ld: got %h want %h", n, load_data, exp_ld); else pass_cnt++;
         if (v && legal && !mis && we && f3 == 3'd2) begin
            total++; if (mem_we !== 1'b1 || mem_addr !== 32'(idx) || mem_wd !== d || stall !== 1'b0) $display("FAIL rnd%0d_sw: got we=%b a=%h d=%h stall=%b", n, mem_we, mem_addr, mem_wd, stall); else pass_cnt++;
            ref_mem[idx] = d;
            @(posedge clk); #1;
         end else if (v && legal && !mis && we) begin
            exp_wd = ref_store(ref_mem[idx], f3, a[1:0], d);
            total++; if (stall !== 1'b1 || mem_we !== 1'b0) $display("FAIL rnd%0d_sub1: got stall=%b we=%b want 1/0", n, stall, mem_we); else pass_cnt++;
            @(posedge clk); #1;
            total++; if (misalign !== 1'b0) $display("FAIL rnd%0d_sub_mis: got %b want 0", n, misalign); else pass_cnt++;
            @(negedge clk);
            set_req(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            #1;
            total++; if (mem_we !== 1'b1 || mem_addr !== 32'(idx) || mem_wd !== exp_wd || stall !== 1'b0) $display("FAIL rnd%0d_sub2: got we=%b a=%h d=%h want 1/%h/%h", n, mem_we, mem_addr, mem_wd, idx, exp_wd); else pass_cnt++;
            ref_mem[idx] = exp_wd;
            @(posedge clk); #1;
            mis = 1'b0;
         end else begin
            total++; if (mem_we !== 1'b0 || stall !== 1'b0) $display("FAIL rnd%0d_ctl: got we=%b stall=%b want 0/0", n, mem_we, stall); else pass_cnt++;
            @(posedge clk); #1;
         end
         total++; if (misalign !== (v && mis)) $display("FAIL rnd%0d_mis: got %b want %b", n, misalign, v && mis); else pass_cnt++;
         total++; if (mem[idx] !== ref_mem[idx]) $display("FAIL rnd%0d_mem: got %h want %h", n, mem[idx], ref_mem[idx]); else pass_cnt++;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      rst_n = 1'b0;
      pl_en = 1'b0;
      pl_idx = 10'd0;
      pl_data = 32'h0;
      clr = 1'b1;
      set_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      @(posedge clk); #1;
      clr = 1'b0;
      test_reset();
      test_sw();
      test_sb();
      test_loads();
      test_misalign();
      test_reset_mrg();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
`default_nettype wire
